// File: rtl/w29ee011_responder_if.sv
// Chip-side bus of a W29EE011-style parallel flash.
// Ports: dut_addr, dut_din, dut_ce/oe/we (programmer), dut_dout, dut_doe (device).
interface w29ee011_responder_if;
  logic [16:0] dut_addr;
  logic [7:0]  dut_din;
  logic [7:0]  dut_dout;
  logic        dut_doe;
  logic        dut_ce;
  logic        dut_oe;
  logic        dut_we;

  modport master (
    output dut_addr, dut_din,
    output dut_ce, dut_oe, dut_we,
    input  dut_dout, dut_doe
  );

  modport slave (
    input  dut_addr, dut_din,
    input  dut_ce, dut_oe, dut_we,
    output dut_dout, dut_doe
  );
endinterface

// File: rtl/w29ee011_responder.sv
// W29EE011-style JEDEC flash responder: SDP decode, page program, chip erase under W29EE011_RESPONDER_ERASE_EN.
// Ports: osc, rst, bus (slave), mem_addr/mem_wdata/mem_we/mem_rdata backing store, busy.
module w29ee011_responder #(
  parameter logic [7:0]  MFG_ID       = 8'hDA,
  parameter logic [7:0]  DEV_ID       = 8'hC1,
  parameter int unsigned LOAD_TIMEOUT = 4800,
  parameter int unsigned PROG_CYCLES  = 240000
) (
  input  logic        osc,
  input  logic        rst,
  w29ee011_responder_if.slave bus,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);
  localparam int unsigned PAGE_SIZE = 128;
  localparam int TW = $clog2(LOAD_TIMEOUT);
  localparam int PW = $clog2(PROG_CYCLES);

  localparam logic [3:0] S_READ    = 4'd0;
  localparam logic [3:0] S_C1      = 4'd1;
  localparam logic [3:0] S_C2      = 4'd2;
  localparam logic [3:0] S_ID      = 4'd3;
  localparam logic [3:0] S_LOAD    = 4'd4;
  localparam logic [3:0] S_PROGRAM = 4'd5;
`ifdef W29EE011_RESPONDER_ERASE_EN
  localparam logic [3:0] S_E1      = 4'd6;
  localparam logic [3:0] S_E2      = 4'd7;
  localparam logic [3:0] S_E3      = 4'd8;
  localparam logic [3:0] S_ERASE   = 4'd9;
`endif

  logic [1:0] ce_s, oe_s, we_s;
  logic       ce_l, oe_l, we_l;
  logic       we_d, oe_d;
  logic       wr_ev, rd_ev;

  logic [3:0] state, origin;
  logic       orig_id;
  logic       have_base;
  logic       last_b7;
  logic       toggle;
  logic [9:0] base;
  logic [TW-1:0] tmr;
  logic [PW-1:0] pc;
  logic [7:0] page_buf [PAGE_SIZE];

  logic [7:0] dout_q, id_data, status;
  logic       doe_q;
  logic [7:0] din;
  logic [9:0] page;
  logic [6:0] off, nxt_off;
  logic       at_5555, at_2aaa;
  logic       cmd_a0, cmd_90, cmd_f0, cmd_80;
  logic       id_view;

  assign bus.dut_dout = dout_q;
  assign bus.dut_doe  = doe_q;

  assign ce_l = ce_s[1];
  assign oe_l = oe_s[1];
  assign we_l = we_s[1];

  // A write wins over a read strobe landing on the same cycle.
  assign wr_ev = we_l & ~we_d & ~ce_l;
  assign rd_ev = ~oe_l & oe_d & ~ce_l & ~wr_ev;

  assign din     = bus.dut_din;
  assign page    = bus.dut_addr[16:7];
  assign off     = bus.dut_addr[6:0];
  assign nxt_off = mem_addr[6:0] + 7'd1;
  assign at_5555 = bus.dut_addr == 17'h05555;
  assign at_2aaa = bus.dut_addr == 17'h02AAA;
  assign cmd_a0  = at_5555 && din == 8'hA0;
  assign cmd_90  = at_5555 && din == 8'h90;
  assign cmd_f0  = at_5555 && din == 8'hF0;
  assign cmd_80  = at_5555 && din == 8'h80;
  assign origin  = orig_id ? S_ID : S_READ;

  // An unlock started from ID keeps showing ID data until it resolves.
  assign id_view = (state == S_ID) ||
                   (orig_id && (state == S_C1 || state == S_C2));

  // DQ7 reads as 0 for the whole erase.
  assign status = {(state == S_PROGRAM) & ~last_b7, toggle, 6'b0};

  always_comb begin
    id_data = 8'hFF;
    unique case (1'b1)
      bus.dut_addr == 17'd0: id_data = MFG_ID;
      bus.dut_addr == 17'd1: id_data = DEV_ID;
      default:               id_data = 8'hFF;
    endcase
  end

  always_ff @(posedge osc) begin
    if (rst) begin
      ce_s <= '0;
      oe_s <= '0;
      we_s <= '0;
      we_d <= 1'b0;
      oe_d <= 1'b0;
    end else begin
      ce_s <= {ce_s[0], bus.dut_ce};
      oe_s <= {oe_s[0], bus.dut_oe};
      we_s <= {we_s[0], bus.dut_we};
      we_d <= we_l;
      oe_d <= oe_l;
    end
  end

  always_ff @(posedge osc) begin
    if (rst) begin
      state     <= S_READ;
      orig_id   <= 1'b0;
      have_base <= 1'b0;
      last_b7   <= 1'b0;
      toggle    <= 1'b0;
      base      <= '0;
      tmr       <= '0;
      pc        <= '0;
      for (int i = 0; i < PAGE_SIZE; i++)
        page_buf[i] <= 8'hFF;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      dout_q    <= 8'h00;
      doe_q     <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      mem_addr <= bus.dut_addr;
      doe_q    <= ~ce_l & ~oe_l & we_l;

      if (busy)
        dout_q <= status;
      else if (id_view)
        dout_q <= id_data;
      else
        dout_q <= mem_rdata;

      if (busy && rd_ev)
        toggle <= ~toggle;

      case (state)
        S_READ, S_ID: begin
          if (wr_ev) begin
            if (at_5555 && din == 8'hAA) begin
              orig_id <= (state == S_ID);
              state   <= S_C1;
            end else if (state == S_ID && din == 8'hF0) begin
              state <= S_READ;
            end
          end
        end

        S_C1: begin
          if (wr_ev)
            state <= (at_2aaa && din == 8'h55) ? S_C2 : origin;
        end

        S_C2: begin
          if (wr_ev) begin
            unique case (1'b1)
              cmd_a0: begin
                state     <= S_LOAD;
                have_base <= 1'b0;
                tmr       <= TW'(LOAD_TIMEOUT - 1);
                for (int i = 0; i < PAGE_SIZE; i++)
                  page_buf[i] <= 8'hFF;
              end
              cmd_90: state <= S_ID;
              cmd_f0: state <= S_READ;
`ifdef W29EE011_RESPONDER_ERASE_EN
              cmd_80: state <= S_E1;
`else
              cmd_80: state <= S_READ;
`endif
              default: state <= origin;
            endcase
          end
        end

        S_LOAD: begin
          if (wr_ev) begin
            tmr <= TW'(LOAD_TIMEOUT - 1);
            if (!have_base || page == base) begin
              page_buf[off] <= din;
              last_b7       <= din[7];
              base          <= page;
              have_base     <= 1'b1;
            end
          end else if (tmr == '0) begin
            // First byte goes out on entry so the burst starts right away.
            state     <= S_PROGRAM;
            busy      <= 1'b1;
            pc        <= '0;
            mem_we    <= 1'b1;
            mem_addr  <= {base, 7'd0};
            mem_wdata <= page_buf[0];
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        S_PROGRAM: begin
          pc <= pc + 1'b1;
          if (pc < PW'(PAGE_SIZE - 1)) begin
            mem_we    <= 1'b1;
            mem_addr  <= {base, nxt_off};
            mem_wdata <= page_buf[nxt_off];
          end
          if (pc == PW'(PROG_CYCLES - 2))
            busy <= 1'b0;
          if (pc == PW'(PROG_CYCLES - 1))
            state <= S_READ;
        end

`ifdef W29EE011_RESPONDER_ERASE_EN
        S_E1: begin
          if (wr_ev)
            state <= (at_5555 && din == 8'hAA) ? S_E2 : S_READ;
        end

        S_E2: begin
          if (wr_ev)
            state <= (at_2aaa && din == 8'h55) ? S_E3 : S_READ;
        end

        S_E3: begin
          if (wr_ev) begin
            if (at_5555 && din == 8'h10) begin
              state     <= S_ERASE;
              busy      <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= '0;
              mem_wdata <= 8'hFF;
            end else begin
              state <= S_READ;
            end
          end
        end

        // mem_addr doubles as the erase cursor.
        S_ERASE: begin
          if (mem_addr != 17'h1FFFF) begin
            mem_we    <= 1'b1;
            mem_addr  <= mem_addr + 1'b1;
            mem_wdata <= 8'hFF;
          end else begin
            state <= S_READ;
          end
          if (mem_addr == 17'h1FFFE)
            busy <= 1'b0;
        end
`endif

        default: state <= S_READ;
      endcase
    end
  end
endmodule

// File: tb/tb_w29ee011_responder.sv
// Scoreboard bench for w29ee011_responder.
// Random SDP sequences and page loads against a sequence-level flash model.
module tb_w29ee011_responder;
  localparam int LT = 200;
  localparam int PC = 2000;
  localparam int MEMSZ = 131072;

  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        osc = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic        busy;

  always #5 osc = ~osc;

  w29ee011_responder_if bus();

  w29ee011_responder #(
    .LOAD_TIMEOUT(LT),
    .PROG_CYCLES(PC)
  ) dut (
    .osc(osc),
    .rst(rst),
    .bus(bus),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  logic [7:0] tmem [MEMSZ];
  logic [7:0] ref_mem [MEMSZ];

  assign mem_rdata = tmem[mem_addr];

  always @(posedge osc) begin
    if (rst) begin
      for (int i = 0; i < MEMSZ; i++) tmem[i] <= ref_mem[i];
    end else if (mem_we) begin
      tmem[mem_addr] <= mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;
  int wpulses = 0;
  int bcount = 0;

  wr_t        wq[$];
  logic [7:0] rq[$];
  event       rd_take;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge osc) if (busy === 1'b1) bcount++;

  always @(negedge osc) begin
    if (!rst && mem_we === 1'b1) begin
      wpulses++;
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_write: unexpected write %h@%h", mem_wdata, mem_addr);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("mem_write", {7'd0, mem_addr, mem_wdata}, {7'd0, e.a, e.d});
      end
    end
  end

  always @(rd_take) begin
    logic [7:0] e;
    e = rq.pop_front();
    chk("read_dout", {23'd0, bus.dut_doe, bus.dut_dout}, {23'd0, 1'b1, e});
  end

  bit         id_mode = 0;
  bit         loading = 0;
  bit         have_base = 0;
  bit         m_busy = 0;
  bit         m_erasing = 0;
  bit         tog = 0;
  logic [7:0] last_byte = 8'h00;
  logic [9:0] m_base = '0;
  logic [7:0] m_page [int];
  wr_t        hist[$];

  function automatic bit is_wr(input wr_t w, input logic [16:0] a,
                               input logic [7:0] d);
    return w.a == a && w.d == d;
  endfunction

  task automatic m_write(input logic [16:0] a, input logic [7:0] d);
    wr_t w;
    int n;
    bit keep;
    w.a = a;
    w.d = d;
    keep = 0;
    if (loading) begin
      if (!have_base) begin
        have_base = 1;
        m_base = a[16:7];
      end
      if (a[16:7] == m_base) begin
        m_page[int'(a[6:0])] = d;
        last_byte = d;
      end
      return;
    end
    hist.push_back(w);
    n = hist.size();
    if (n == 1) begin
      if (!is_wr(w, 17'h05555, 8'hAA)) begin
        if (id_mode && d == 8'hF0) id_mode = 0;
        hist.delete();
      end
    end else if (n == 2) begin
      if (!is_wr(w, 17'h02AAA, 8'h55)) hist.delete();
    end else if (n == 3) begin
      if (is_wr(w, 17'h05555, 8'hA0)) begin
        loading = 1;
        have_base = 0;
        m_page.delete();
      end else if (is_wr(w, 17'h05555, 8'h90)) begin
        id_mode = 1;
      end else if (is_wr(w, 17'h05555, 8'hF0)) begin
        id_mode = 0;
      end else if (is_wr(w, 17'h05555, 8'h80)) begin
        id_mode = 0;
`ifdef W29EE011_RESPONDER_ERASE_EN
        keep = 1;
`endif
      end
      if (!keep) hist.delete();
    end else begin
      if ((n == 4 && !is_wr(w, 17'h05555, 8'hAA)) ||
          (n == 5 && !is_wr(w, 17'h02AAA, 8'h55)) ||
          (n == 6 && !is_wr(w, 17'h05555, 8'h10))) begin
        hist.delete();
      end else if (n == 6) begin
        hist.delete();
        m_erasing = 1;
        for (int i = 0; i < MEMSZ; i++) begin
          wr_t e;
          e.a = 17'(i);
          e.d = 8'hFF;
          wq.push_back(e);
          ref_mem[i] = 8'hFF;
        end
      end
    end
  endtask

  task automatic m_commit();
    for (int i = 0; i < 128; i++) begin
      wr_t e;
      e.a = {m_base, 7'(i)};
      e.d = m_page.exists(i) ? m_page[i] : 8'hFF;
      wq.push_back(e);
      ref_mem[int'(e.a)] = e.d;
    end
    loading = 0;
    id_mode = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [16:0] a);
    if (m_busy)
      return {m_erasing ? 1'b0 : ~last_byte[7], tog, 6'b0};
    if (id_mode)
      return a == 17'd0 ? 8'hDA : (a == 17'd1 ? 8'hC1 : 8'hFF);
    return ref_mem[int'(a)];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge osc);
  endtask

  task automatic bus_write(input logic [16:0] a, input logic [7:0] d);
    m_write(a, d);
    bus.dut_addr = a;
    bus.dut_din  = d;
    bus.dut_ce   = 1'b0;
    idle(2);
    bus.dut_we = 1'b0;
    idle(4);
    bus.dut_we = 1'b1;
    idle(6);
    bus.dut_ce = 1'b1;
    idle(3);
  endtask

  task automatic bus_read(input logic [16:0] a);
    bus.dut_addr = a;
    bus.dut_ce   = 1'b0;
    bus.dut_oe   = 1'b0;
    idle(8);
    if (m_busy) tog = ~tog;
    rq.push_back(m_read(a));
    ->rd_take;
    idle(1);
    bus.dut_oe = 1'b1;
    bus.dut_ce = 1'b1;
    idle(4);
  endtask

  task automatic unlock(input logic [7:0] cmd);
    bus_write(17'h05555, 8'hAA);
    bus_write(17'h02AAA, 8'h55);
    bus_write(17'h05555, cmd);
  endtask

  task automatic wait_busy(input logic lvl, input int lim, input string nm);
    int n;
    n = 0;
    while (busy !== lvl && n < lim) begin
      @(negedge osc);
      n++;
    end
    chk(nm, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic run_busy(input int exp_len, input int pulses);
    int w0;
    int b0;
    int len;
    w0 = wpulses;
    wait_busy(1'b1, LT + 50, "busy_rise");
    b0 = bcount;
    m_busy = 1;
    repeat (4) bus_read(17'($urandom));
    wait_busy(1'b0, exp_len + 100, "busy_fall");
    len = bcount - b0;
    m_busy = 0;
    m_erasing = 0;
    chk("busy_len_ok", {31'd0, len >= exp_len - 2 && len <= exp_len + 2}, 32'd1);
    idle(5);
    chk("write_pulses", wpulses - w0, pulses);
    chk("wq_drained", wq.size(), 0);
  endtask

  task automatic page_program(input logic [9:0] pg, input int n, input bit stray);
    logic [16:0] a[$];
    unlock(8'hA0);
    for (int i = 0; i < n; i++) begin
      logic [16:0] x;
      x = {pg, 7'($urandom)};
      a.push_back(x);
      bus_write(x, 8'($urandom));
      if (stray && i == 0) bus_write({pg ^ 10'h1, 7'($urandom)}, 8'($urandom));
    end
    m_commit();
    run_busy(PC, 128);
    foreach (a[i]) bus_read(a[i]);
    bus_read({pg, 7'($urandom)});
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    bus.dut_addr = '0;
    bus.dut_din  = '0;
    bus.dut_ce   = 1'b1;
    bus.dut_oe   = 1'b1;
    bus.dut_we   = 1'b1;
    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'($urandom);
    idle(6);
    chk("rst_doe", {31'd0, bus.dut_doe}, 32'd0);
    chk("rst_dout", {24'd0, bus.dut_dout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    rst = 1'b0;
    idle(6);

    repeat (4) bus_read(17'($urandom));

    unlock(8'h90);
    bus_read(17'd0);
    bus_read(17'd1);
    bus_read(17'($urandom_range(2, MEMSZ - 1)));
    bus_write(17'($urandom), 8'hF0);
    bus_read(17'd0);

    w0 = wpulses;
    bus_write(17'h01234, 8'h55);
    idle(20);
    chk("unprot_no_write", wpulses - w0, 0);
    bus_read(17'h01234);

    bus_write(17'h05555, 8'hAA);
    bus_write(17'h02AAA, 8'h54);
    bus_read(17'($urandom));

    unlock(8'hA0);
    bus_write(17'h00180, 8'h12);
    bus_write(17'h00181, 8'h34);
    bus_write(17'h00182, 8'h56);
    m_commit();
    run_busy(PC, 128);
    for (int i = 0; i < 4; i++) bus_read(17'h00180 + 17'(i));

    for (int k = 0; k < 3; k++)
      page_program(10'($urandom), $urandom_range(1, 8), k[0]);

    w0 = wpulses;
    unlock(8'h80);
    bus_write(17'h05555, 8'hAA);
    bus_write(17'h02AAA, 8'h55);
    bus_write(17'h05555, 8'h10);
`ifdef W29EE011_RESPONDER_ERASE_EN
    run_busy(MEMSZ, MEMSZ);
`else
    idle(30);
    chk("erase_off_no_write", wpulses - w0, 0);
    chk("erase_off_busy", {31'd0, busy}, 32'd0);
`endif
    bus_read(17'($urandom));
    bus_read(17'h00181);

    idle(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/w29ee011_responder.md
# w29ee011_responder

- Cycle-level model of a Winbond W29EE011-style JEDEC parallel flash: the device end of the programmer's #CE/#OE/#WE bus.
- Samples the chip-side strobes, decodes software-data-protected command sequences (product ID, page write, chip erase), buffers a 128-byte page and commits it to a backing memory port.
- Drives read data, product ID and DQ7/DQ6 status.
- Used as an in-FPGA target and a bench model for the programmer's write and read engines.

## Interface
- PAGE_SIZE, 128, bytes per page; page base is addr[16:7].
- MFG_ID, 8'hDA, manufacturer ID returned at address 0 in ID mode.
- DEV_ID, 8'hC1, device ID returned at address 1 in ID mode.
- LOAD_TIMEOUT, 4800, idle cycles after the last page-load write before programming starts (200 us at 24 MHz).
- PROG_CYCLES, 240000, total busy cycles for a page program (10 ms).
- osc  in  1  24 MHz clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- dut_addr  in  17  A16..A0 from the bus.
- dut_din  in  8  DQ7..DQ0 driven by the programmer.
- dut_dout  out  8  DQ7..DQ0 driven by this block.
- dut_doe  out  1  output enable for dut_dout.
- dut_ce, dut_oe, dut_we  in  1 each  active-low strobes; asynchronous to osc.
- mem_addr  out  17  backing memory address.
- mem_wdata  out  8  backing memory write data.
- mem_we  out  1  backing memory write strobe, one byte per cycle.
- mem_rdata  in  8  backing memory read data; combinational from mem_addr.
- busy  out  1  high during PROGRAM or ERASE.

## Operation
- **Input sampling**
  - dut_ce, dut_oe and dut_we each pass through a 2-FF synchronizer.
  - A write event is a synchronized #WE rising edge while synchronized #CE is low; dut_addr and dut_din are captured on that cycle.
  - A read strobe is a synchronized #OE falling edge while #CE is low.
- **States:** READ, C1, C2, ID, LOAD, PROGRAM, E1, E2, E3, ERASE.
- **Command decode**
  - READ/ID: AA@5555 -> C1; any other write is ignored.
  - C1: 55@2AAA -> C2; otherwise return to the origin state (READ or ID).
  - C2 with A0@5555 -> LOAD (page buffer cleared to FF).
  - C2 with 90@5555 -> ID.
  - C2 with F0@5555 -> READ.
  - C2 with 80@5555 -> E1.
  - C2 with any other write -> origin state.
  - In ID, a single F0 write at any address -> READ.
- **Erase entry:** E1 takes AA@5555 -> E2; E2 takes 55@2AAA -> E3; E3 takes 10@5555 -> ERASE. A mismatch at any of these steps -> READ.
- **LOAD**
  - The first write fixes the page base.
  - Each write with matching addr[16:7] stores din at buf[addr[6:0]]; a later write to the same offset overwrites.
  - Writes to another page are dropped.
  - The timeout counter reloads on every write; on expiry -> PROGRAM.
- **PROGRAM**
  - Asserts mem_we for PAGE_SIZE consecutive cycles at base+0..base+127, with data buf[i] (unloaded bytes = FF).
  - Holds busy until PROG_CYCLES have elapsed since PROGRAM entry, then -> READ.
  - Writes on the bus are ignored.
- **ERASE:** writes FF to addresses 0..0x1FFFF, one per cycle, then -> READ.
- **Read data** (registered; dut_doe = !ce & !oe & we after sync):
  - READ: mem_rdata at dut_addr.
  - ID: addr 0 -> MFG_ID, addr 1 -> DEV_ID, other addresses -> FF.
  - busy: DQ7 = ~bit7 of the last loaded byte (00 during ERASE), DQ6 = toggle bit, other bits 0.
  - The toggle bit inverts on every read strobe while busy.

## Timing
- All registers reset to zero, except the following:
  - state = READ
  - buffer = FF
  - dut_doe = 0
  - dut_dout = 00
  - mem_we = 0
  - busy = 0
  - toggle = 0
- **Pin edge to internal effect:** 3 osc cycles (2 sync + edge detect). The programmer must hold addr/data at least 4 cycles past #WE rise; the writer provides 24.
- **Read latency:** dut_dout is valid 4 cycles after the last of #CE, #OE or address changes.
- **Program commit:** mem_we starts 1 cycle after LOAD timeout expiry.
- **busy** rises in the same cycle as PROGRAM/ERASE entry and falls 1 cycle before returning to READ.
- **rst mid-PROGRAM/ERASE:** the operation is aborted immediately and memory is left partially written.
- **Simultaneous #WE and #OE activity:** a write event takes priority; the read is suppressed for that cycle.

## Configuration
- **W29EE011_RESPONDER_ERASE_EN defined:** the 80 -> AA -> 55 -> 10 chip-erase path is implemented.
- **Undefined:** 80@5555 in C2 returns to READ; states E1..E3 and ERASE do not exist.

## Test plan
- AA@5555, 55@2AAA, 90@5555, then read addr 0 and addr 1 -> DA, C1; then F0, read addr 0 -> memory contents.
- Unlock + A0, load 3 bytes 12/34/56 at 0x00180..0x00182, idle -> busy for 240000 cycles, mem_we 128 pulses, 0x180..0x182 = 12/34/56, 0x183 = FF.
- Reads during that program -> DQ7 = 1 (~bit7 of 56), DQ6 alternating 0/1 on consecutive #OE strobes.
- Unprotected write 55@0x1234 in READ -> no mem_we, state stays READ.
- Wrong second unlock byte (AA@5555, 54@2AAA) -> READ; a subsequent valid sequence still works.
- With ERASE_EN: full erase sequence -> busy, 131072 mem_we pulses of FF; without ERASE_EN, the same sequence -> no mem_we.
